instr_fetch_unit: RTL and testbench

Instruction fetch stage for the MIPS-style processor. It owns the program counter, reads instructions from an external instruction memory over a request/acknowledge handshake, and holds the fetched word stable for the control unit and datapath. When the datapath signals commit, the next PC is computed from the branch/jump/zero outcome and the next fetch is issued.

---
 rtl/instr_fetch_unit.sv | 99 +++++++++
 tb/tb_instr_fetch_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over a
// req/ack memory port and holds it until the datapath commits.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  input  logic        commit,
  output logic [31:0] retired,
  output logic [1:0]  state_dbg
);

  // Handshakes: imem_req stays high with imem_addr stable until a cycle with
  // imem_ack high, and that cycle transfers imem_rdata. instr_valid stays high
  // with instr/pc stable until a cycle with commit high, which retires it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] next_pc;
  logic [31:0] branch_off;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign state_dbg = state;

  // Jump keeps the 256 MB region of pc_plus4; branch offset is in words.
  always_comb begin
    branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    next_pc    = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      retired     <= 32'd0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            state       <= EXEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        EXEC: begin
          if (commit) begin
            pc          <= next_pc;
            retired     <= retired + 32'd1;
            instr_valid <= 1'b0;
            if (run) begin
              state    <= FETCH;
              imem_req <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit with a PC reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run, imem_req, imem_ack, instr_valid;
  logic        branch, jump, zero, commit;
  logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4, retired;
  logic [1:0]  state_dbg;

  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc2, pc4_2, ret2;
  logic [1:0]  st2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_ret_q[$];
  int          exp_len_q[$];
  logic [31:0] cfg_word_q[$];
  int          cfg_wait_q[$];

  logic [31:0] model_pc, model_instr, model_ret;
  bit          mon_en, force_ack, jump_done;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .branch(branch), .jump(jump), .zero(zero), .commit(commit),
    .retired(retired), .state_dbg(state_dbg)
  );

  // Second instance placed at 0x4000_0000 with every control input held high.
  instr_fetch_unit #(.RESET_PC(32'h4000_0000)) dut_jmp (
    .clk(clk), .rst_n(rst_n), .run(1'b1),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(1'b1), .imem_rdata(32'h0800_0040),
    .instr(instr2), .instr_valid(valid2), .pc(pc2), .pc_plus4(pc4_2),
    .branch(1'b1), .jump(1'b1), .zero(1'b1), .commit(1'b1),
    .retired(ret2), .state_dbg(st2)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected at %0t", name, $time);
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] ins,
                                           input bit br, input bit jp, input bit zr);
    logic [31:0] seq_pc;
    longint      off;
    seq_pc = cur_pc + 32'd4;
    if (jp) return (seq_pc & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (br && zr) begin
      off = longint'($signed(ins[15:0]));
      return seq_pc + 32'(off * 4);
    end
    return seq_pc;
  endfunction

  // Memory: serves each fetch after its configured number of wait cycles.
  initial begin : mem_responder
    int          cnt;
    bit          busy;
    logic [31:0] word;
    busy = 0; cnt = 0; word = 0;
    imem_ack = 1'b0; imem_rdata = 32'd0; model_instr = 32'd0;
    forever begin
      @(posedge clk); #2;
      if (imem_req) begin
        if (!busy) begin
          busy = 1;
          if (cfg_word_q.size() > 0) begin
            word = cfg_word_q.pop_front();
            cnt  = cfg_wait_q.pop_front();
          end else begin
            word = $urandom;
            cnt  = $urandom_range(0, 3);
          end
          exp_len_q.push_back(cnt + 1);
        end
        if (cnt == 0) begin
          imem_ack    = 1'b1;
          imem_rdata  = word;
          model_instr = word;
          exp_instr_q.push_back(word);
          busy = 0;
        end else begin
          cnt--;
          imem_ack   = 1'b0;
          imem_rdata = $urandom;
        end
      end else begin
        busy       = 0;
        imem_ack   = force_ack ? 1'b1 : 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a fetch or an instruction.
  initial begin : monitor
    bit          p_req, p_valid, p_ack;
    int          req_len;
    logic [31:0] cur_addr, cur_instr;
    p_req = 0; p_valid = 0; p_ack = 0; req_len = 0; cur_addr = 0; cur_instr = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (imem_req && !p_req) begin
          if (exp_addr_q.size() == 0) fail_now("fetch_unexpected");
          else begin
            cur_addr = exp_addr_q.pop_front();
            check32("fetch_addr", imem_addr, cur_addr);
          end
          req_len = 1;
        end else if (imem_req) begin
          req_len++;
          check32("addr_hold", imem_addr, cur_addr);
        end
        if (!imem_req && p_req) begin
          if (exp_len_q.size() == 0) fail_now("req_len_unexpected");
          else check32("req_cycles", 32'(req_len), 32'(exp_len_q.pop_front()));
        end
        if (instr_valid && !p_valid) begin
          check32("valid_after_ack", {31'd0, p_ack}, 32'd1);
          if (exp_instr_q.size() == 0) fail_now("instr_unexpected");
          else begin
            cur_instr = exp_instr_q.pop_front();
            check32("instr", instr, cur_instr);
          end
        end else if (instr_valid) begin
          check32("instr_hold", instr, cur_instr);
        end
        if (!instr_valid && p_valid) begin
          if (exp_ret_q.size() == 0) fail_now("retire_unexpected");
          else check32("retired", retired, exp_ret_q.pop_front());
        end
      end
      p_req   = imem_req;
      p_valid = instr_valid;
      p_ack   = imem_ack && imem_req;
    end
  end

  // Jump priority on the instance placed at 0x4000_0000.
  initial begin : jump_probe
    int rises;
    bit p;
    rises = 0; p = 0; jump_done = 0;
    @(posedge rst_n);
    for (int c = 0; c < 20 && rises < 2; c++) begin
      @(negedge clk);
      if (req2 && !p) begin
        rises++;
        if (rises == 1) check32("jump_first_fetch", addr2, 32'h4000_0000);
        else check32("jump_priority", addr2, 32'h4000_0100);
      end
      p = req2;
    end
    if (rises < 2) fail_now("jump_probe_timeout");
    jump_done = 1;
  end

  // One instruction: configure memory, wait for EXEC, dwell, then commit.
  task automatic run_instr(input logic [31:0] word, input int waits, input int dwell,
                           input bit br, input bit jp, input bit zr, input bit rn);
    int          t;
    logic [31:0] nxt;
    cfg_word_q.push_back(word);
    cfg_wait_q.push_back(waits);
    t = 0;
    while (!instr_valid && t < 200) begin
      commit = 1'($urandom_range(0, 1));
      branch = 1'($urandom_range(0, 1));
      jump   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      t++;
    end
    if (!instr_valid) begin
      fail_now("exec_timeout");
      commit = 1'b0;
      return;
    end
    for (int d = 0; d < dwell; d++) begin
      commit = 1'b0;
      branch = 1'($urandom_range(0, 1));
      jump   = 1'($urandom_range(0, 1));
      zero   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    check32("pc", pc, model_pc);
    check32("pc_plus4", pc_plus4, model_pc + 32'd4);
    commit = 1'b1; branch = br; jump = jp; zero = zr; run = rn;
    nxt       = ref_next(model_pc, model_instr, br, jp, zr);
    model_pc  = nxt;
    model_ret = model_ret + 32'd1;
    exp_addr_q.push_back(nxt);
    exp_ret_q.push_back(model_ret);
    @(posedge clk); #1;
    commit = 1'b0;
    branch = 1'($urandom_range(0, 1));
    jump   = 1'($urandom_range(0, 1));
    zero   = 1'($urandom_range(0, 1));
  endtask

  initial begin : driver
    int w;
    run = 1'b1; commit = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0;
    force_ack = 0; mon_en = 0;
    model_pc = RESET_PC; model_ret = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    check32("rst_req", {31'd0, imem_req}, 32'd0);
    check32("rst_valid", {31'd0, instr_valid}, 32'd0);
    check32("rst_pc", pc, RESET_PC);
    check32("rst_instr", instr, 32'd0);
    check32("rst_retired", retired, 32'd0);
    exp_addr_q.push_back(RESET_PC);
    mon_en = 1;
    rst_n  = 1'b1;
    #1 check32("idle_after_release", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    check32("fetch_start", {31'd0, imem_req}, 32'd1);

    // Sequential fetch with zero-wait memory.
    run_instr(32'h2008_0001, 0, 0, 0, 0, 0, 1);
    run_instr(32'h2009_0002, 0, 0, 0, 0, 0, 1);
    run_instr(32'h012A_5820, 0, 0, 0, 0, 0, 1);
    check32("retired_after_3", retired, 32'd3);
    // Three wait states at 0xC.
    run_instr(32'h8C08_0000, 3, 1, 0, 0, 0, 1);
    // BEQ -2 at 0x10, taken then not taken.
    run_instr(32'h1000_FFFE, 0, 0, 1, 0, 1, 1);
    run_instr(32'h0000_0000, 0, 0, 0, 0, 0, 1);
    run_instr(32'h1000_FFFE, 0, 0, 1, 0, 0, 1);
    // Jumps across a 256 MB region boundary; jump overrides a taken branch.
    run_instr(32'h0BFF_FFFF, 0, 0, 1, 1, 1, 1);
    run_instr(32'h0800_0040, 0, 0, 0, 1, 0, 1);

    // Reset in the middle of a waiting fetch.
    cfg_word_q.push_back(32'hDEAD_BEEF);
    cfg_wait_q.push_back(5);
    repeat (2) @(posedge clk);
    #4;
    mon_en = 0;
    rst_n  = 1'b0;
    #1;
    check32("async_rst_req", {31'd0, imem_req}, 32'd0);
    check32("async_rst_valid", {31'd0, instr_valid}, 32'd0);
    check32("async_rst_pc", pc, RESET_PC);
    check32("async_rst_retired", retired, 32'd0);
    @(posedge clk); #1;
    force_ack = 1; run = 1'b0; rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check32("late_ack_req", {31'd0, imem_req}, 32'd0);
      check32("late_ack_valid", {31'd0, instr_valid}, 32'd0);
      check32("late_ack_instr", instr, 32'd0);
    end
    force_ack = 0;
    exp_addr_q.delete(); exp_instr_q.delete(); exp_ret_q.delete(); exp_len_q.delete();
    cfg_word_q.delete(); cfg_wait_q.delete();
    model_pc = RESET_PC; model_ret = 32'd0;
    exp_addr_q.push_back(RESET_PC);
    mon_en = 1;
    run = 1'b1;

    // Branch below zero to 0xFFFF_FFFC, stop with run low, wrap to 0.
    run_instr(32'h1000_FFFE, 0, 0, 1, 0, 1, 1);
    run_instr(32'h2010_0007, 1, 0, 0, 0, 0, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check32("stop_req", {31'd0, imem_req}, 32'd0);
      check32("stop_valid", {31'd0, instr_valid}, 32'd0);
      check32("wrap_pc", pc, model_pc);
    end
    run = 1'b1;
    run_instr(32'h2011_0008, 0, 0, 0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 150; i++) begin
      bit rn;
      rn = ($urandom_range(0, 7) != 0);
      run_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), rn);
      if (!rn) begin
        w = $urandom_range(1, 3);
        for (int k = 0; k < w; k++) begin
          @(posedge clk); #1;
          check32("idle_hold", {31'd0, imem_req}, 32'd0);
        end
        run = 1'b1;
      end
    end
    run_instr($urandom, 0, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    check32("ret_q_drained", 32'(exp_ret_q.size()), 32'd0);
    check32("instr_q_drained", 32'(exp_instr_q.size()), 32'd0);
    check32("addr_q_pending", 32'(exp_addr_q.size()), 32'd1);
    if (!jump_done) fail_now("jump_probe_unfinished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
